uart_rx_ctrl: RTL

Receive-side frame controller for the UART RX path. It consumes the oversampling tick derived from the RX clock divider and the serial `rx` line. It sequences start detection, mid-bit majority sampling, data shift, optional parity check and stop check, then delivers each received byte with a one-cycle valid strobe and per-frame error flags. It sits between the RX clock divider and the RX byte consumer (FIFO or register interface).

---
 rtl/uart_rx_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller with 2-of-3 mid-bit sampling, optional parity and stop checks
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  rx,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);
    localparam int M  = OVERSAMPLE / 2;
    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;

    logic                  rx_m, rx_s;
    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [2:0]            samp;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_l, par_typ_l, par_bad;
    logic                  s3, maj, bit_end, last_bit, eval;

    // third sample is taken live on the M+1 tick so the majority is usable on that same tick
    assign s3       = (edge_cnt == EW'(M + 1)) ? rx_s : samp[2];
    assign maj      = (samp[0] & samp[1]) | (samp[0] & s3) | (samp[1] & s3);
    assign bit_end  = edge_cnt == EW'(OVERSAMPLE - 1);
    assign last_bit = bit_cnt == BW'(DATA_WIDTH - 1);
    assign eval     = tick && state == STOP && edge_cnt == EW'(M + 1);
    assign busy     = state != IDLE;

    always_comb begin
        state_nx = state;
        if (tick)
            case (state)
                IDLE:    state_nx = rx_s ? IDLE : START;
                START:   state_nx = !bit_end ? START : maj ? IDLE : DATA;
                DATA:    state_nx = !(bit_end && last_bit) ? DATA : par_en_l ? PARITY : STOP;
                PARITY:  state_nx = bit_end ? STOP : PARITY;
                STOP:    state_nx = eval ? IDLE : STOP;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_m, rx_s} <= 2'b11;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            samp         <= '0;
            shreg        <= '0;
            par_en_l     <= 1'b0;
            par_typ_l    <= 1'b0;
            par_bad      <= 1'b0;
            data         <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
        end else begin
            {rx_m, rx_s} <= {rx, rx_m};
            data_valid   <= eval & maj & ~par_bad;
            par_err      <= eval & par_bad;
            stop_err     <= eval & ~maj;
            if (eval && maj && !par_bad) data <= shreg;
            if (tick) begin
                // the start-detect tick is edge 0 of the start bit, so the next tick is edge 1
                edge_cnt <= (state == IDLE) ? EW'(!rx_s) : (bit_end || eval) ? '0 : edge_cnt + EW'(1);
                if (edge_cnt == EW'(M - 1)) samp[0] <= rx_s;
                if (edge_cnt == EW'(M)) samp[1] <= rx_s;
                if (edge_cnt == EW'(M + 1)) samp[2] <= rx_s;
                if (state == IDLE && !rx_s) begin
                    par_en_l  <= par_en;
                    par_typ_l <= par_typ;
                    par_bad   <= 1'b0;
                end
                if (state == DATA && bit_end) begin
                    shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                    bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
                end
                if (state == PARITY && bit_end) par_bad <= maj != (^shreg ^ par_typ_l);
            end
        end
    end
endmodule
